nx_node_loader: RTL and testbench
=================================

// Module: nx_node_loader
//
// PURPOSE
// - Upstream feeder for nx_node_store's write port. Consumes the node's inbound
//   load-message stream (valid/ready, one LOAD_DATA_W chunk per message).
// - Packs chunks LSB-first into RAM_DATA_W words and issues registered
//   single-cycle writes at an auto-incrementing address.
// - Supports address set, data append and partial-word flush. Reports words
//   loaded and a sticky overflow error.
//
// PARAMETERS
// - RAM_ADDR_W   10  store address width; must be <= LOAD_DATA_W
// - RAM_DATA_W   32  store word width; must be an integer multiple of LOAD_DATA_W
// - LOAD_DATA_W  16  payload width of one load message
//   (CHUNKS = RAM_DATA_W / LOAD_DATA_W)
//
// PORTS
// - i_clk           in   1              clock
// - i_rst           in   1              reset, asynchronous, active-high
// - i_msg_op        in   2              node_load_op_t: ADDR / DATA / FLUSH / RSVD
// - i_msg_data      in   LOAD_DATA_W    message payload
// - i_msg_valid     in   1              message present
// - o_msg_ready     out  1              message accepted when valid & ready
// - o_wr_addr       out  RAM_ADDR_W     store write address   (-> i_wr_addr)
// - o_wr_data       out  RAM_DATA_W     store write data      (-> i_wr_data)
// - o_wr_en         out  1              store write strobe    (-> i_wr_en)
// - o_word_count    out  RAM_ADDR_W+1   words written since reset, saturating
// - o_overflow      out  1              sticky: write attempted past top of store
//
// BEHAVIOUR
// - Reset: o_wr_addr/o_wr_data/o_wr_en/o_word_count/o_overflow = 0.
//   o_msg_ready = 0 while i_rst is high. Internal pointer, chunk index,
//   accumulator and wrapped flag = 0.
// - Reset mid-word: discards partial data; no write is emitted.
// - Ready: o_msg_ready = !o_overflow. No other backpressure; the store write
//   port never stalls.
// - ADDR:
//   - ptr <= i_msg_data[RAM_ADDR_W-1:0]; clears the wrapped flag.
//   - Discards any partial word (chunk <= 0); no write.
// - DATA:
//   - acc[chunk*LOAD_DATA_W +: LOAD_DATA_W] <= payload.
//   - If chunk == CHUNKS-1, completes the word, then chunk <= 0. Otherwise
//     chunk++.
// - FLUSH:
//   - If chunk != 0, completes the word with unfilled upper chunks zeroed,
//     then chunk <= 0.
//   - If chunk == 0, no-op.
// - RSVD: accepted and ignored.
// - Word completion:
//   - Cycle after acceptance: o_wr_en = 1 for exactly one cycle,
//     o_wr_addr = ptr, o_wr_data = assembled word. Latency is 1 cycle.
//   - The completing chunk is included combinationally; no stale data.
//   - Then ptr++ (mod 2^RAM_ADDR_W) and o_word_count++ (saturates at
//     all-ones).
//   - A write at ptr == 2^RAM_ADDR_W-1 sets the wrapped flag.
// - Overflow:
//   - A completion while the wrapped flag is set is suppressed (o_wr_en
//     stays 0) and sets o_overflow.
//   - o_overflow is sticky until reset; o_msg_ready drops the following
//     cycle.
// - Back-to-back: one message per cycle is sustained. Consecutive
//   completions give consecutive o_wr_en pulses.
// - o_wr_addr/o_wr_data hold their last value when o_wr_en = 0.
//
// STRUCTURE
// - NXConstants: typedef enum logic [1:0] node_load_op_t
//   { NODE_LOAD_ADDR=0, NODE_LOAD_DATA=1, NODE_LOAD_FLUSH=2, NODE_LOAD_RSVD=3 }.
//   LOAD_DATA_W default constant also lives there.
// - Single module, no sub-module.
// - Registers: ptr, chunk index, accumulator, wrapped, overflow, count,
//   output write stage.
// - Elaboration-time assertions on the parameter constraints.
//
// TESTING
// - Reset, ADDR 0x010, DATA 0xBEEF, DATA 0xDEAD
//   -> one cycle later o_wr_en=1, addr 0x010, data 0xDEADBEEF; count=1.
// - ADDR 0x020, DATA 0x1234, FLUSH
//   -> write addr 0x020 data 0x00001234. A second FLUSH emits no write.
// - ADDR 0x3FF, 4x DATA (0x0001..0x0004)
//   -> write 0x3FF=0x00020001; second word suppressed; o_overflow=1;
//   o_msg_ready=0 next cycle.
// - 8 DATA messages back-to-back at one per cycle
//   -> 4 writes on alternate cycles, addresses n..n+3, count +4.
// - DATA 0xAAAA, ADDR 0x005, DATA 0x1111, DATA 0x2222
//   -> 0xAAAA is dropped; single write 0x005=0x22221111.
// - DATA 0x5555, then assert i_rst
//   -> all outputs 0 with no write. After release, DATA 0x1,0x2 writes
//   addr 0 = 0x00020001.

Source files
------------

// File: rtl/NXConstants.sv
// Shared constants for the node load path: load-message opcodes and the
// default load payload width.
package NXConstants;

   typedef enum logic [1:0] {
      NODE_LOAD_ADDR  = 2'd0,
      NODE_LOAD_DATA  = 2'd1,
      NODE_LOAD_FLUSH = 2'd2,
      NODE_LOAD_RSVD  = 2'd3
   } node_load_op_t;

   localparam int NX_LOAD_DATA_W = 16;

endpackage

// File: rtl/nx_node_loader.sv
// Packs inbound load-message chunks LSB-first into store words and issues
// registered single-cycle writes at an auto-incrementing address.
module nx_node_loader
   import NXConstants::*;
#(
   parameter int RAM_ADDR_W  = 10,
   parameter int RAM_DATA_W  = 32,
   parameter int LOAD_DATA_W = NX_LOAD_DATA_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  node_load_op_t          i_msg_op,
   input  logic [LOAD_DATA_W-1:0] i_msg_data,
   input  logic                   i_msg_valid,
   output logic                   o_msg_ready,
   output logic [RAM_ADDR_W-1:0]  o_wr_addr,
   output logic [RAM_DATA_W-1:0]  o_wr_data,
   output logic                   o_wr_en,
   output logic [RAM_ADDR_W:0]    o_word_count,
   output logic                   o_overflow
);

   localparam int CHUNKS  = RAM_DATA_W / LOAD_DATA_W;
   localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CHUNK_W-1:0]    LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
   localparam logic [RAM_ADDR_W-1:0] TOP_ADDR   = '1;
   localparam logic [RAM_ADDR_W:0]   COUNT_MAX  = '1;

   if (RAM_DATA_W % LOAD_DATA_W != 0 || RAM_DATA_W < LOAD_DATA_W) begin : g_bad_ratio
      $error("nx_node_loader: RAM_DATA_W must be an integer multiple of LOAD_DATA_W");
   end
   if (RAM_ADDR_W > LOAD_DATA_W) begin : g_bad_addr
      $error("nx_node_loader: RAM_ADDR_W must not exceed LOAD_DATA_W");
   end

   logic [RAM_ADDR_W-1:0] r_ptr;
   logic [CHUNK_W-1:0]    r_chunk;
   logic [RAM_DATA_W-1:0] r_acc;
   logic                  r_wrapped;
   logic                  r_overflow;
   logic [RAM_ADDR_W:0]   r_count;
   logic                  r_wr_en;
   logic [RAM_ADDR_W-1:0] r_wr_addr;
   logic [RAM_DATA_W-1:0] r_wr_data;

   logic                  w_accept;
   logic                  w_is_data;
   logic                  w_is_flush;
   logic                  w_complete;
   logic [RAM_DATA_W-1:0] w_word;

   assign o_msg_ready = !r_overflow && !i_rst;
   assign w_accept    = i_msg_valid && o_msg_ready;
   assign w_is_data   = (i_msg_op == NODE_LOAD_DATA);
   assign w_is_flush  = (i_msg_op == NODE_LOAD_FLUSH);
   assign w_complete  = w_accept &&
                        ((w_is_data && r_chunk == LAST_CHUNK) ||
                         (w_is_flush && r_chunk != '0));

   // The accumulator is kept zero above the fill point, so a flushed word
   // already has its unfilled upper chunks cleared.
   always_comb begin
      // NOTE: default first so every path assigns w_word and no latch is inferred.
      w_word = r_acc;
      if (w_is_data) begin
         w_word[int'(r_chunk) * LOAD_DATA_W +: LOAD_DATA_W] = i_msg_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr      <= '0;
         r_chunk    <= '0;
         r_acc      <= '0;
         r_wrapped  <= 1'b0;
         r_overflow <= 1'b0;
         r_count    <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         // NOTE: non-blocking throughout; later assignments in this block override earlier ones.
         r_wr_en <= 1'b0;

         if (w_accept) begin
            unique case (i_msg_op)
               NODE_LOAD_ADDR: begin
                  r_ptr     <= i_msg_data[RAM_ADDR_W-1:0];
                  r_wrapped <= 1'b0;
                  r_chunk   <= '0;
                  r_acc     <= '0;
               end
               NODE_LOAD_DATA: begin
                  if (r_chunk == LAST_CHUNK) begin
                     r_chunk <= '0;
                     r_acc   <= '0;
                  end else begin
                     r_chunk <= r_chunk + CHUNK_W'(1);
                     r_acc   <= w_word;
                  end
               end
               NODE_LOAD_FLUSH: begin
                  r_chunk <= '0;
                  r_acc   <= '0;
               end
               default: ;
            endcase
         end

         if (w_complete) begin
            if (r_wrapped) begin
               r_overflow <= 1'b1;
            end else begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_ptr;
               r_wr_data <= w_word;
               r_ptr     <= r_ptr + RAM_ADDR_W'(1);
               if (r_count != COUNT_MAX) r_count <= r_count + (RAM_ADDR_W+1)'(1);
               if (r_ptr == TOP_ADDR) r_wrapped <= 1'b1;
            end
         end
      end
   end

   assign o_wr_en      = r_wr_en;
   assign o_wr_addr    = r_wr_addr;
   assign o_wr_data    = r_wr_data;
   assign o_word_count = r_count;
   assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_nx_node_loader.sv
// Directed-vector bench for nx_node_loader: inputs change on the falling
// edge, outputs are sampled on the falling edge after the registering edge.
module tb_nx_node_loader;
   import NXConstants::*;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b0;
   node_load_op_t i_msg_op = NODE_LOAD_RSVD;
   logic [15:0]   i_msg_data = '0;
   logic          i_msg_valid = 1'b0;
   logic          o_msg_ready;
   logic [9:0]    o_wr_addr;
   logic [31:0]   o_wr_data;
   logic          o_wr_en;
   logic [10:0]   o_word_count;
   logic          o_overflow;

   int total = 0;
   int bad   = 0;
   int exp_count = 0;

   nx_node_loader #(.RAM_ADDR_W(10), .RAM_DATA_W(32), .LOAD_DATA_W(16)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_msg_op    (i_msg_op),
      .i_msg_data  (i_msg_data),
      .i_msg_valid (i_msg_valid),
      .o_msg_ready (o_msg_ready),
      .o_wr_addr   (o_wr_addr),
      .o_wr_data   (o_wr_data),
      .o_wr_en     (o_wr_en),
      .o_word_count(o_word_count),
      .o_overflow  (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic send(input node_load_op_t op, input logic [15:0] data);
      @(negedge i_clk);
      i_msg_op    = op;
      i_msg_data  = data;
      i_msg_valid = 1'b1;
      @(posedge i_clk);
   endtask

   task automatic idle();
      @(negedge i_clk);
      i_msg_valid = 1'b0;
      i_msg_op    = NODE_LOAD_RSVD;
   endtask

   task automatic pulse_reset();
      @(negedge i_clk);
      i_msg_valid = 1'b0;
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      exp_count = 0;
   endtask

   task automatic test_reset();
      #2 i_rst = 1'b1;
      #1;
      total++; if (o_wr_en !== 1'b0)    begin bad++; $display("FAIL reset_wr_en: got %b want 0", o_wr_en); end
      total++; if (o_wr_addr !== 10'h0) begin bad++; $display("FAIL reset_wr_addr: got %h want 000", o_wr_addr); end
      total++; if (o_wr_data !== 32'h0) begin bad++; $display("FAIL reset_wr_data: got %h want 0", o_wr_data); end
      total++; if (o_word_count !== 11'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", o_word_count); end
      total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
      total++; if (o_msg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %b want 0", o_msg_ready); end
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      total++; if (o_msg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_high: got %b want 1", o_msg_ready); end
   endtask

   task automatic test_basic_word();
      send(NODE_LOAD_ADDR, 16'h0010);
      send(NODE_LOAD_DATA, 16'hBEEF);
      idle();
      total++; if (o_wr_en !== 1'b0) begin bad++; $display("FAIL basic_half_word_no_write: got %b want 0", o_wr_en); end
      send(NODE_LOAD_DATA, 16'hDEAD);
      idle();
      exp_count++;
      total++; if (o_wr_en !== 1'b1)            begin bad++; $display("FAIL basic_wr_en: got %b want 1", o_wr_en); end
      total++; if (o_wr_addr !== 10'h010)       begin bad++; $display("FAIL basic_wr_addr: got %h want 010", o_wr_addr); end
      total++; if (o_wr_data !== 32'hDEADBEEF)  begin bad++; $display("FAIL basic_wr_data: got %h want deadbeef", o_wr_data); end
      total++; if (o_word_count !== 11'(exp_count)) begin bad++; $display("FAIL basic_count: got %0d want %0d", o_word_count, exp_count); end
      @(negedge i_clk);
      total++; if (o_wr_en !== 1'b0)            begin bad++; $display("FAIL basic_single_pulse: got %b want 0", o_wr_en); end
      total++; if (o_wr_data !== 32'hDEADBEEF)  begin bad++; $display("FAIL basic_data_hold: got %h want deadbeef", o_wr_data); end
   endtask

   task automatic test_flush();
      send(NODE_LOAD_ADDR, 16'h0020);
      send(NODE_LOAD_DATA, 16'h1234);
      send(NODE_LOAD_FLUSH, 16'h0000);
      idle();
      exp_count++;
      total++; if (o_wr_en !== 1'b1)           begin bad++; $display("FAIL flush_wr_en: got %b want 1", o_wr_en); end
      total++; if (o_wr_addr !== 10'h020)      begin bad++; $display("FAIL flush_wr_addr: got %h want 020", o_wr_addr); end
      total++; if (o_wr_data !== 32'h00001234) begin bad++; $display("FAIL flush_wr_data: got %h want 00001234", o_wr_data); end
      send(NODE_LOAD_FLUSH, 16'h0000);
      idle();
      total++; if (o_wr_en !== 1'b0)           begin bad++; $display("FAIL flush_empty_no_write: got %b want 0", o_wr_en); end
      total++; if (o_word_count !== 11'(exp_count)) begin bad++; $display("FAIL flush_count: got %0d want %0d", o_word_count, exp_count); end
      send(NODE_LOAD_RSVD, 16'hFFFF);
      idle();
      total++; if (o_wr_en !== 1'b0)           begin bad++; $display("FAIL rsvd_no_write: got %b want 0", o_wr_en); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] lo, hi;
      logic [9:0]  exp_addr;
      send(NODE_LOAD_ADDR, 16'h0100);
      for (int i = 0; i <= 8; i++) begin
         @(negedge i_clk);
         if (i > 0) begin
            total++;
            if (o_wr_en !== ((i % 2) == 0)) begin bad++; $display("FAIL b2b_wr_en[%0d]: got %b want %b", i, o_wr_en, ((i % 2) == 0)); end
            if ((i % 2) == 0) begin
               lo = 16'h1000 + 16'(i - 2);
               hi = 16'h1000 + 16'(i - 1);
               exp_addr = 10'h100 + 10'(i / 2 - 1);
               total++; if (o_wr_addr !== exp_addr) begin bad++; $display("FAIL b2b_wr_addr[%0d]: got %h want %h", i, o_wr_addr, exp_addr); end
               total++; if (o_wr_data !== {hi, lo}) begin bad++; $display("FAIL b2b_wr_data[%0d]: got %h want %h", i, o_wr_data, {hi, lo}); end
            end
         end
         if (i < 8) begin
            i_msg_op    = NODE_LOAD_DATA;
            i_msg_data  = 16'h1000 + 16'(i);
            i_msg_valid = 1'b1;
         end else begin
            i_msg_valid = 1'b0;
         end
         @(posedge i_clk);
      end
      exp_count += 4;
      @(negedge i_clk);
      total++; if (o_word_count !== 11'(exp_count)) begin bad++; $display("FAIL b2b_count: got %0d want %0d", o_word_count, exp_count); end
   endtask

   task automatic test_addr_discard();
      send(NODE_LOAD_DATA, 16'hAAAA);
      send(NODE_LOAD_ADDR, 16'h0005);
      idle();
      total++; if (o_wr_en !== 1'b0) begin bad++; $display("FAIL discard_no_write: got %b want 0", o_wr_en); end
      send(NODE_LOAD_DATA, 16'h1111);
      send(NODE_LOAD_DATA, 16'h2222);
      idle();
      exp_count++;
      total++; if (o_wr_en !== 1'b1)           begin bad++; $display("FAIL discard_wr_en: got %b want 1", o_wr_en); end
      total++; if (o_wr_addr !== 10'h005)      begin bad++; $display("FAIL discard_wr_addr: got %h want 005", o_wr_addr); end
      total++; if (o_wr_data !== 32'h22221111) begin bad++; $display("FAIL discard_wr_data: got %h want 22221111", o_wr_data); end
   endtask

   task automatic test_overflow();
      send(NODE_LOAD_ADDR, 16'h03FF);
      send(NODE_LOAD_DATA, 16'h0001);
      send(NODE_LOAD_DATA, 16'h0002);
      idle();
      exp_count++;
      total++; if (o_wr_en !== 1'b1)           begin bad++; $display("FAIL ovf_top_wr_en: got %b want 1", o_wr_en); end
      total++; if (o_wr_addr !== 10'h3FF)      begin bad++; $display("FAIL ovf_top_wr_addr: got %h want 3ff", o_wr_addr); end
      total++; if (o_wr_data !== 32'h00020001) begin bad++; $display("FAIL ovf_top_wr_data: got %h want 00020001", o_wr_data); end
      total++; if (o_overflow !== 1'b0)        begin bad++; $display("FAIL ovf_not_yet: got %b want 0", o_overflow); end
      send(NODE_LOAD_DATA, 16'h0003);
      send(NODE_LOAD_DATA, 16'h0004);
      idle();
      total++; if (o_wr_en !== 1'b0)           begin bad++; $display("FAIL ovf_suppressed: got %b want 0", o_wr_en); end
      total++; if (o_overflow !== 1'b1)        begin bad++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
      total++; if (o_msg_ready !== 1'b0)       begin bad++; $display("FAIL ovf_ready_low: got %b want 0", o_msg_ready); end
      total++; if (o_wr_addr !== 10'h3FF)      begin bad++; $display("FAIL ovf_addr_hold: got %h want 3ff", o_wr_addr); end
      total++; if (o_word_count !== 11'(exp_count)) begin bad++; $display("FAIL ovf_count: got %0d want %0d", o_word_count, exp_count); end
      send(NODE_LOAD_ADDR, 16'h0000);
      idle();
      total++; if (o_overflow !== 1'b1)        begin bad++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
   endtask

   task automatic test_reset_mid_word();
      pulse_reset();
      send(NODE_LOAD_DATA, 16'h5555);
      @(negedge i_clk);
      i_msg_valid = 1'b0;
      i_rst = 1'b1;
      #1;
      total++; if (o_wr_en !== 1'b0)       begin bad++; $display("FAIL midrst_wr_en: got %b want 0", o_wr_en); end
      total++; if (o_wr_data !== 32'h0)    begin bad++; $display("FAIL midrst_wr_data: got %h want 0", o_wr_data); end
      total++; if (o_word_count !== 11'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", o_word_count); end
      total++; if (o_overflow !== 1'b0)    begin bad++; $display("FAIL midrst_overflow: got %b want 0", o_overflow); end
      @(negedge i_clk);
      i_rst = 1'b0;
      send(NODE_LOAD_DATA, 16'h0001);
      send(NODE_LOAD_DATA, 16'h0002);
      idle();
      total++; if (o_wr_en !== 1'b1)           begin bad++; $display("FAIL midrst_after_wr_en: got %b want 1", o_wr_en); end
      total++; if (o_wr_addr !== 10'h000)      begin bad++; $display("FAIL midrst_after_addr: got %h want 000", o_wr_addr); end
      total++; if (o_wr_data !== 32'h00020001) begin bad++; $display("FAIL midrst_after_data: got %h want 00020001", o_wr_data); end
      total++; if (o_word_count !== 11'd1)     begin bad++; $display("FAIL midrst_after_count: got %0d want 1", o_word_count); end
   endtask

   initial begin
      test_reset();
      test_basic_word();
      test_flush();
      test_back_to_back();
      test_addr_discard();
      test_overflow();
      test_reset_mid_word();
      repeat (2) @(negedge i_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
